id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter SHALL be: XLEN, 32, datapath width.
REQ-002 i_clk  in  1  sole clock, all state on rising edge.
REQ-003 i_rst_n  in  1  asynchronous, active-low reset.
REQ-004 i_clk_enable  in  1  global advance qualifier; low freezes all state.
REQ-005 i_id_valid, i_id_instr, i_id_pc  in  1/32/XLEN  IF/ID slot contents.
REQ-006 o_rs1_addr, o_rs2_addr  out  5/5  register-file read addresses, instr[19:15]/[24:20].
REQ-007 i_rs1_data, i_rs2_data  in  XLEN/XLEN  register-file read data.
REQ-008 i_wb_reg_write, i_wb_addr, i_wb_data  in  1/5/XLEN  writeback port, same as feeds the register file.
REQ-009 i_flush  in  1  taken branch/jump from EX; kills the ID/EX slot.
REQ-010 o_stall  out  1  load-use hazard; IF/ID and PC SHALL hold.
REQ-011 o_ex_valid, o_ex_pc, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm  out  1/XLEN x4  ID/EX slot.
REQ-012 o_ex_rd, o_ex_rs1_addr, o_ex_rs2_addr, o_ex_opcode, o_ex_funct3, o_ex_funct7b5, o_ex_mem_read  out  5/5/5/7/3/1/1  ID/EX slot.

Function
REQ-013 Addresses on o_rs1_addr/o_rs2_addr SHALL be combinational from i_id_instr.
REQ-014 Bypass: if i_wb_reg_write and i_wb_addr!=0 and i_wb_addr equals rsN addr, captured rsN data SHALL be i_wb_data, else i_rsN_data.
REQ-015 Immediate SHALL be generated per opcode: I (0000011, 0010011, 1100111, 1110011), S (0100011), B (1100011), U (0110111, 0010111), J (1101111), sign-extended to XLEN; other opcodes give 0.
REQ-016 rs1 used: all opcodes except LUI, AUIPC, JAL; rs2 used: 0110011, 0100011, 1100011.
REQ-017 o_stall SHALL be combinational: o_ex_valid & o_ex_mem_read & o_ex_rd!=0 & i_id_valid & ((rs1 used & o_ex_rd==rs1) | (rs2 used & o_ex_rd==rs2)).
REQ-018 Each enabled edge, priority: i_flush -> o_ex_valid<=0; else o_stall -> o_ex_valid<=0 (bubble); else capture all slot fields, o_ex_valid<=i_id_valid.
REQ-019 o_ex_mem_read SHALL be opcode==0000011; o_ex_rd instr[11:7], forced 0 for S and B types.
REQ-020 Bubble/flush SHALL also clear o_ex_mem_read and o_ex_rd so stall never self-sustains; stall lasts exactly one cycle per load-use.
REQ-021 Latency: one enabled cycle from IF/ID to ID/EX outputs.
REQ-022 i_clk_enable low SHALL hold every register, including during flush or stall.
REQ-023 Simultaneous flush and stall: flush wins; o_stall still asserts combinationally that cycle.
REQ-024 Register x0 SHALL never be bypassed nor cause a stall.

Reset
REQ-025 i_rst_n low SHALL immediately clear all ID/EX registers to 0, independent of i_clk and i_clk_enable.
REQ-026 Reset mid-operation SHALL discard the in-flight slot; o_stall SHALL read 0 while reset held.
REQ-027 First enabled edge after deassertion SHALL capture normally.

Structure
REQ-028 Opcode constants and immediate-type enum SHALL live in the shared riscv package.
REQ-029 Immediate generation SHALL be one sub-module, imm_gen, combinational.
REQ-030 Hazard and bypass logic SHALL stay inline in id_ex_stage.

Verification
REQ-031 addi x5,x0,-1 (0xFFF00293), pc 0x100 -> next edge o_ex_imm=0xFFFFFFFF, o_ex_rd=5, o_ex_pc=0x100, valid=1.
REQ-032 rs1=x3, i_rs1_data=0x11, WB writes x3=0x22 same cycle -> o_ex_rs1_data=0x22; same with addr 0 -> 0 from register file path.
REQ-033 lw x6 in ID/EX, add x7,x6,x1 in IF/ID -> o_stall=1 one cycle, bubble valid=0, then add captured with stall=0.
REQ-034 lw x6 then sw x6,0(x2) (rs2 hazard) -> stall; lw x0 then add x7,x0,x1 -> no stall.
REQ-035 i_flush with valid IF/ID -> o_ex_valid=0 next edge; i_clk_enable=0 for 3 cycles -> outputs unchanged.
REQ-036 i_rst_n dropped mid-cycle between edges -> all outputs 0 before next edge.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared RV32 opcode constants, immediate formats and operand-use
//            decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_IMM    = 7'b0010011;
    localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_REG    = 7'b0110011;
    localparam logic [6:0] C_OP_LUI    = 7'b0110111;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_JALR   = 7'b1100111;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;
    localparam logic [6:0] C_OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
        imm_type_e t;
        case (opcode)
            C_OP_LOAD, C_OP_IMM, C_OP_JALR, C_OP_SYSTEM: t = IMM_I;
            C_OP_STORE:                                   t = IMM_S;
            C_OP_BRANCH:                                  t = IMM_B;
            C_OP_LUI, C_OP_AUIPC:                         t = IMM_U;
            C_OP_JAL:                                     t = IMM_J;
            default:                                      t = IMM_NONE;
        endcase
        return t;
    endfunction

    function automatic logic rs1_used(input logic [6:0] opcode);
        return !(opcode == C_OP_LUI || opcode == C_OP_AUIPC || opcode == C_OP_JAL);
    endfunction

    function automatic logic rs2_used(input logic [6:0] opcode);
        return (opcode == C_OP_REG || opcode == C_OP_STORE || opcode == C_OP_BRANCH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen
// Brief    : Combinational RV32 immediate decoder, sign-extended to XLEN.
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm
);

    imm_type_e   w_type;
    logic [31:0] w_imm32;

    assign w_type = imm_type_of(i_instr[6:0]);

    always_comb begin
        w_imm32 = 32'd0;
        case (w_type)
            IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U:   w_imm32 = {i_instr[31:12], 12'd0};
            IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = 32'd0;
        endcase
    end

    generate
        if (XLEN > 32) begin : g_sext
            assign o_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_native
            assign o_imm = w_imm32[XLEN-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with writeback bypass, immediate decode
//            and load-use stall detection.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clk_enable,
    input  logic            i_id_valid,
    input  logic [31:0]     i_id_instr,
    input  logic [XLEN-1:0] i_id_pc,
    output logic [4:0]      o_rs1_addr,
    output logic [4:0]      o_rs2_addr,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic            i_wb_reg_write,
    input  logic [4:0]      i_wb_addr,
    input  logic [XLEN-1:0] i_wb_data,
    input  logic            i_flush,
    output logic            o_stall,
    output logic            o_ex_valid,
    output logic [XLEN-1:0] o_ex_pc,
    output logic [XLEN-1:0] o_ex_rs1_data,
    output logic [XLEN-1:0] o_ex_rs2_data,
    output logic [XLEN-1:0] o_ex_imm,
    output logic [4:0]      o_ex_rd,
    output logic [4:0]      o_ex_rs1_addr,
    output logic [4:0]      o_ex_rs2_addr,
    output logic [6:0]      o_ex_opcode,
    output logic [2:0]      o_ex_funct3,
    output logic            o_ex_funct7b5,
    output logic            o_ex_mem_read
);

    logic [6:0]      w_opcode;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rs1_fwd;
    logic [XLEN-1:0] w_rs2_fwd;
    logic            w_rs1_hit;
    logic            w_rs2_hit;
    logic            w_no_rd;

    logic            valid_d,    valid_q;
    logic [XLEN-1:0] pc_d,       pc_q;
    logic [XLEN-1:0] rs1_data_d, rs1_data_q;
    logic [XLEN-1:0] rs2_data_d, rs2_data_q;
    logic [XLEN-1:0] imm_d,      imm_q;
    logic [4:0]      rd_d,       rd_q;
    logic [4:0]      rs1_addr_d, rs1_addr_q;
    logic [4:0]      rs2_addr_d, rs2_addr_q;
    logic [6:0]      opcode_d,   opcode_q;
    logic [2:0]      funct3_d,   funct3_q;
    logic            funct7b5_d, funct7b5_q;
    logic            mem_read_d, mem_read_q;

    assign w_opcode   = i_id_instr[6:0];
    assign o_rs1_addr = i_id_instr[19:15];
    assign o_rs2_addr = i_id_instr[24:20];

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_instr (i_id_instr),
        .o_imm   (w_imm)
    );

    // x0 is hard-wired zero, so a writeback to it must never win over the file.
    assign w_rs1_fwd = (i_wb_reg_write && i_wb_addr != 5'd0 && i_wb_addr == o_rs1_addr)
                       ? i_wb_data : i_rs1_data;
    assign w_rs2_fwd = (i_wb_reg_write && i_wb_addr != 5'd0 && i_wb_addr == o_rs2_addr)
                       ? i_wb_data : i_rs2_data;

    assign w_rs1_hit = rs1_used(w_opcode) && (rd_q == o_rs1_addr);
    assign w_rs2_hit = rs2_used(w_opcode) && (rd_q == o_rs2_addr);
    assign o_stall   = valid_q && mem_read_q && (rd_q != 5'd0) && i_id_valid
                       && (w_rs1_hit || w_rs2_hit);

    assign w_no_rd = (w_opcode == C_OP_STORE) || (w_opcode == C_OP_BRANCH);

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rd_d       = rd_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        opcode_d   = opcode_q;
        funct3_d   = funct3_q;
        funct7b5_d = funct7b5_q;
        mem_read_d = mem_read_q;
        // Clearing rd and mem_read on a bubble stops the stall re-triggering.
        if (i_flush || o_stall) begin
            valid_d    = 1'b0;
            rd_d       = 5'd0;
            mem_read_d = 1'b0;
        end else begin
            valid_d    = i_id_valid;
            pc_d       = i_id_pc;
            rs1_data_d = w_rs1_fwd;
            rs2_data_d = w_rs2_fwd;
            imm_d      = w_imm;
            rd_d       = w_no_rd ? 5'd0 : i_id_instr[11:7];
            rs1_addr_d = o_rs1_addr;
            rs2_addr_d = o_rs2_addr;
            opcode_d   = w_opcode;
            funct3_d   = i_id_instr[14:12];
            funct7b5_d = i_id_instr[30];
            mem_read_d = (w_opcode == C_OP_LOAD);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rd_q       <= 5'd0;
            rs1_addr_q <= 5'd0;
            rs2_addr_q <= 5'd0;
            opcode_q   <= 7'd0;
            funct3_q   <= 3'd0;
            funct7b5_q <= 1'b0;
            mem_read_q <= 1'b0;
        end else if (i_clk_enable) begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rd_q       <= rd_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            opcode_q   <= opcode_d;
            funct3_q   <= funct3_d;
            funct7b5_q <= funct7b5_d;
            mem_read_q <= mem_read_d;
        end
    end

    assign o_ex_valid    = valid_q;
    assign o_ex_pc       = pc_q;
    assign o_ex_rs1_data = rs1_data_q;
    assign o_ex_rs2_data = rs2_data_q;
    assign o_ex_imm      = imm_q;
    assign o_ex_rd       = rd_q;
    assign o_ex_rs1_addr = rs1_addr_q;
    assign o_ex_rs2_addr = rs2_addr_q;
    assign o_ex_opcode   = opcode_q;
    assign o_ex_funct3   = funct3_q;
    assign o_ex_funct7b5 = funct7b5_q;
    assign o_ex_mem_read = mem_read_q;

endmodule
`default_nettype wire
